// File: rtl/dpram_arb_pkg.sv
// ============================================================================
// Module : dpram_arb_pkg
// Purpose: Shared definitions for the port-B arbiter of the dual-port RAM:
//          lock FSM state encoding, master IDs and the clogb2 width helper.
// Ports  : none (package)
// Config : DPRAM_ARB_RR_EN (used by dpram_arb; no effect here)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dpram_arb_pkg;

  typedef enum logic [0:0] {
    DPRAM_ARB_IDLE  = 1'b0,
    DPRAM_ARB_LOCK1 = 1'b1
  } arb_state_e;

  localparam logic M0 = 1'b0;  // core load/store unit
  localparam logic M1 = 1'b1;  // ISP / debug loader

  // Number of bits needed to represent value (at least 1).
  function automatic int clogb2(input int value);
    int v;
    int n;
    n = 0;
    for (v = value; v > 0; v = v >> 1) begin
      n = n + 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_arb_resp.sv
// ============================================================================
// Module : dpram_arb_resp
// Purpose: Response router. Remembers which master owned the RAM access in
//          the previous cycle and whether it was a read, then steers the
//          RAM's registered read data to that master only.
// Ports  : clk_i, rst_i          - clock, synchronous active-high reset
//          acc_i, id_i, we_i     - access taken this cycle, owner, write flag
//          doutb_i               - RAM port-B read data (1-cycle latency)
//          m0_/m1_rvalid_o       - read data valid per master
//          m0_/m1_rdata_o        - read data per master (0 when not valid)
// Config : none
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_arb_resp
  import dpram_arb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        acc_i,
  input  logic        id_i,
  input  logic        we_i,
  input  logic [31:0] doutb_i,
  output logic        m0_rvalid_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic [31:0] m1_rdata_o
);

  logic owner_q, owner_d;
  logic rd_q, rd_d;

  assign rd_d    = acc_i & ~we_i;
  assign owner_d = acc_i ? id_i : owner_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= M0;
      rd_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    if (rd_q) begin
      if (owner_q == M1) begin
        m1_rvalid_o = 1'b1;
        m1_rdata_o  = doutb_i;
      end else begin
        m0_rvalid_o = 1'b1;
        m0_rdata_o  = doutb_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dpram_arb.sv
// ============================================================================
// Module : dpram_arb
// Purpose: Arbiter/sequencer for port B of the dual-port data/instruction
//          RAM. Shares the port between the core LSU (m0) and the loader (m1),
//          supports a loader lock for exclusive bursts and routes read data.
// Ports  : clk_i, rst_i                       - clock, sync active-high reset
//          mX_req/we/wem/addr/wdata_i         - master request channels
//          m1_lock_i                          - loader exclusive-burst request
//          mX_gnt_o                           - request accepted this cycle
//          mX_rvalid_o / mX_rdata_o           - read responses
//          enb/web/wemb/addrb/dinb_o, doutb_i - RAM port B
// Config : DPRAM_ARB_RR_EN - round-robin on contended cycles instead of
//          fixed m0-first priority.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_arb
  import dpram_arb_pkg::*;
#(
  parameter int RAM_DEPTH = 2048,
  parameter int AW        = clogb2(RAM_DEPTH - 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_wem_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [31:0]   m0_wdata_i,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_wem_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [31:0]   m1_wdata_i,
  input  logic          m1_lock_i,
  output logic          m0_gnt_o,
  output logic          m1_gnt_o,
  output logic          m0_rvalid_o,
  output logic          m1_rvalid_o,
  output logic [31:0]   m0_rdata_o,
  output logic [31:0]   m1_rdata_o,
  output logic          enb_o,
  output logic          web_o,
  output logic [3:0]    wemb_o,
  output logic [AW-1:0] addrb_o,
  output logic [31:0]   dinb_o,
  input  logic [31:0]   doutb_i
);

  arb_state_e state_q, state_d;
  logic       gnt_id;

`ifdef DPRAM_ARB_RR_EN
  // Master favoured on the next contended cycle.
  logic rr_q, rr_d;
`endif

  // Grant: LOCK1 hands the port to m1 alone (idle cycles keep ownership).
  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    if (state_q == DPRAM_ARB_LOCK1) begin
      m1_gnt_o = m1_req_i;
    end else begin
`ifdef DPRAM_ARB_RR_EN
      if (m0_req_i && m1_req_i) begin
        m0_gnt_o = (rr_q == M0);
        m1_gnt_o = (rr_q == M1);
      end else begin
        m0_gnt_o = m0_req_i;
        m1_gnt_o = m1_req_i;
      end
`else
      m0_gnt_o = m0_req_i;
      m1_gnt_o = m1_req_i & ~m0_req_i;
`endif
    end
  end

  // Lock FSM. Leaving LOCK1 still blocks m0 for the cycle in which
  // m1_lock_i=0 is sampled, because the grant above looks at state_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DPRAM_ARB_IDLE:  if (m1_gnt_o && m1_lock_i) state_d = DPRAM_ARB_LOCK1;
      DPRAM_ARB_LOCK1: if (!m1_lock_i)            state_d = DPRAM_ARB_IDLE;
      default:                                    state_d = DPRAM_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= DPRAM_ARB_IDLE;
    else       state_q <= state_d;
  end

`ifdef DPRAM_ARB_RR_EN
  // Pointer moves only when both masters competed in IDLE; the loser of
  // this cycle is favoured next time.
  always_comb begin
    rr_d = rr_q;
    if (state_q == DPRAM_ARB_IDLE && m0_req_i && m1_req_i) begin
      rr_d = m0_gnt_o ? M1 : M0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= M0;
    else       rr_q <= rr_d;
  end
`endif

  // RAM port-B drive, all-zero when nobody is granted.
  always_comb begin
    enb_o   = 1'b0;
    web_o   = 1'b0;
    wemb_o  = '0;
    addrb_o = '0;
    dinb_o  = '0;
    gnt_id  = M0;
    if (m0_gnt_o) begin
      enb_o   = 1'b1;
      web_o   = m0_we_i;
      wemb_o  = m0_wem_i;
      addrb_o = m0_addr_i;
      dinb_o  = m0_wdata_i;
      gnt_id  = M0;
    end else if (m1_gnt_o) begin
      enb_o   = 1'b1;
      web_o   = m1_we_i;
      wemb_o  = m1_wem_i;
      addrb_o = m1_addr_i;
      dinb_o  = m1_wdata_i;
      gnt_id  = M1;
    end
  end

  dpram_arb_resp u_resp (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .acc_i       (enb_o),
    .id_i        (gnt_id),
    .we_i        (web_o),
    .doutb_i     (doutb_i),
    .m0_rvalid_o (m0_rvalid_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_rdata_o  (m1_rdata_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_dpram_arb.sv
// ============================================================================
// Module : tb_dpram_arb
// Purpose: Self-checking bench for dpram_arb with a behavioural port-B RAM
//          and a response scoreboard.
// Config : DPRAM_ARB_RR_EN selects the round-robin expectations.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dpram_arb;
  import dpram_arb_pkg::*;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [3:0]    m0_wem, m1_wem;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          enb, web;
  logic [3:0]    wemb;
  logic [AW-1:0] addrb;
  logic [31:0]   dinb;
  logic [31:0]   doutb = '0;

  logic [31:0]   mem [0:2047];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          due;
    bit          who;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  dpram_arb dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_wem_i(m0_wem),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_wem_i(m1_wem),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_lock_i(m1_lock),
    .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
    .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
    .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
    .enb_o(enb), .web_o(web), .wemb_o(wemb), .addrb_o(addrb), .dinb_o(dinb),
    .doutb_i(doutb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM port B: byte-masked write, registered read.
  always @(posedge clk) begin
    if (enb) begin
      if (web) begin
        for (int b = 0; b < 4; b++)
          if (wemb[b]) mem[addrb][8*b +: 8] <= dinb[8*b +: 8];
      end else begin
        doutb <= mem[addrb];
      end
    end
  end

  // Response monitor: every cycle either the head of the scoreboard is due,
  // or both masters must see rvalid=0 and rdata=0.
  always @(negedge clk) begin
    logic        ev0, ev1;
    logic [31:0] ed0, ed1;
    exp_t        e;
    if (mon_en) begin
      ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
      if (sb.size() > 0 && sb[0].due < cyc) begin
        total++; bad++;
        $display("FAIL resp_missing: cycle=%0d expected response due at %0d never matched", cyc, sb[0].due);
        e = sb.pop_front();
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        if (e.who == M1) begin ev1 = 1'b1; ed1 = e.data; end
        else             begin ev0 = 1'b1; ed0 = e.data; end
      end
      total++;
      if ({m0_rvalid, m1_rvalid} !== {ev0, ev1}) begin
        bad++;
        $display("FAIL rvalid: cycle=%0d got m0/m1=%b%b want %b%b", cyc, m0_rvalid, m1_rvalid, ev0, ev1);
      end
      total++;
      if (m0_rdata !== ed0) begin
        bad++;
        $display("FAIL m0_rdata: cycle=%0d got %h want %h", cyc, m0_rdata, ed0);
      end
      total++;
      if (m1_rdata !== ed1) begin
        bad++;
        $display("FAIL m1_rdata: cycle=%0d got %h want %h", cyc, m1_rdata, ed1);
      end
    end
  end

  task automatic drive_idle();
    m0_req = 0; m0_we = 0; m0_wem = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_wem = '0; m1_addr = '0; m1_wdata = '0;
    m1_lock = 0;
  endtask

  task automatic m0_cmd(input logic we, input logic [3:0] wem,
                        input logic [AW-1:0] a, input logic [31:0] d);
    m0_req = 1; m0_we = we; m0_wem = wem; m0_addr = a; m0_wdata = d;
  endtask

  task automatic m1_cmd(input logic we, input logic [3:0] wem,
                        input logic [AW-1:0] a, input logic [31:0] d);
    m1_req = 1; m1_we = we; m1_wem = wem; m1_addr = a; m1_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      bad++; $display("FAIL reset_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid);
    end
    total++;
    if ({m0_rdata, m1_rdata} !== 64'd0) begin
      bad++; $display("FAIL reset_rdata: got %h %h want 0 0", m0_rdata, m1_rdata);
    end
    total++;
    if ({m0_gnt, m1_gnt, enb, web, wemb, addrb, dinb} !== '0) begin
      bad++; $display("FAIL reset_idle_drive: gnt=%b%b enb=%b addrb=%h want all 0", m0_gnt, m1_gnt, enb, addrb);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    drive_idle();
    m0_cmd(1'b0, 4'h0, 11'h010, 32'h0);
    sb.push_back('{cyc + 1, M0, 32'hDEADBEEF});
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, enb, web} !== 4'b1010) begin
      bad++; $display("FAIL read_grant: gnt=%b%b enb=%b web=%b want 1010", m0_gnt, m1_gnt, enb, web);
    end
    total++;
    if (addrb !== 11'h010) begin
      bad++; $display("FAIL read_addr: got %h want 010", addrb);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_write_strobe();
    @(posedge clk); #1;
    drive_idle();
    m1_cmd(1'b1, 4'b0101, 11'h005, 32'h11223344);
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, enb, web, wemb} !== 8'b0111_0101) begin
      bad++; $display("FAIL wstrb_drive: gnt=%b%b enb=%b web=%b wemb=%b want 01 1 1 0101", m0_gnt, m1_gnt, enb, web, wemb);
    end
    total++;
    if (addrb !== 11'h005 || dinb !== 32'h11223344) begin
      bad++; $display("FAIL wstrb_data: addrb=%h dinb=%h want 005 11223344", addrb, dinb);
    end
    @(posedge clk); #1;
    drive_idle();
    m0_cmd(1'b0, 4'h0, 11'h005, 32'h0);
    sb.push_back('{cyc + 1, M0, 32'hAA22CC44});
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1) begin
      bad++; $display("FAIL wstrb_readback_gnt: got %b want 1", m0_gnt);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_contend();
    logic w;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      m0_cmd(1'b0, 4'h0, 11'h010, 32'h0);
      m1_cmd(1'b0, 4'h0, 11'h005, 32'h0);
`ifdef DPRAM_ARB_RR_EN
      w = (k % 2 == 1) ? M1 : M0;
`else
      w = M0;
`endif
      sb.push_back('{cyc + 1, w, (w == M1) ? 32'hAA22CC44 : 32'hDEADBEEF});
      @(negedge clk);
      total++;
      if (m0_gnt !== (w == M0) || m1_gnt !== (w == M1)) begin
        bad++; $display("FAIL contend_gnt[%0d]: got m0/m1=%b%b want winner m%0d", k, m0_gnt, m1_gnt, w);
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_lock();
    @(posedge clk); #1;
    drive_idle();
    m1_cmd(1'b1, 4'hF, 11'h030, 32'hCAFE0001);
    m1_lock = 1'b1;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      bad++; $display("FAIL lock_enter_gnt: got %b%b want 01", m0_gnt, m1_gnt);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      m1_req = 1'b0;
      m0_cmd(1'b0, 4'h0, 11'h010, 32'h0);
      @(negedge clk);
      total++;
      if ({m0_gnt, enb} !== 2'b00) begin
        bad++; $display("FAIL lock_hold[%0d]: m0_gnt=%b enb=%b want 0 0", k, m0_gnt, enb);
      end
    end
    @(posedge clk); #1;
    m1_lock = 1'b0;
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b0) begin
      bad++; $display("FAIL lock_exit_cycle: m0_gnt=%b want 0", m0_gnt);
    end
    @(posedge clk); #1;
    sb.push_back('{cyc + 1, M0, 32'hDEADBEEF});
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1) begin
      bad++; $display("FAIL lock_release: m0_gnt=%b want 1", m0_gnt);
    end
    @(posedge clk); #1;
    m0_cmd(1'b0, 4'h0, 11'h030, 32'h0);
    sb.push_back('{cyc + 1, M0, 32'hCAFE0001});
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1) begin
      bad++; $display("FAIL lock_readback_gnt: m0_gnt=%b want 1", m0_gnt);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_nop_write();
    @(posedge clk); #1;
    drive_idle();
    m0_cmd(1'b1, 4'b0000, 11'h020, 32'hFFFFFFFF);
    @(negedge clk);
    total++;
    if ({enb, web, wemb} !== 6'b11_0000 || dinb !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL nop_write_drive: enb=%b web=%b wemb=%b dinb=%h want 1 1 0000 ffffffff", enb, web, wemb, dinb);
    end
    @(posedge clk); #1;
    m0_cmd(1'b0, 4'h0, 11'h020, 32'h0);
    sb.push_back('{cyc + 1, M0, 32'h12345678});
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1) begin
      bad++; $display("FAIL nop_write_readback_gnt: got %b want 1", m0_gnt);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    drive_idle();
    m1_cmd(1'b0, 4'h0, 11'h010, 32'h0);
    m1_lock = 1'b1;
    sb.push_back('{cyc + 1, M1, 32'hDEADBEEF});
    @(negedge clk);
    total++;
    if (m1_gnt !== 1'b1) begin
      bad++; $display("FAIL rstmid_first_gnt: got %b want 1", m1_gnt);
    end
    // Locked read issued in the reset cycle: its response must be squashed.
    @(posedge clk); #1;
    rst = 1'b1;
    m1_cmd(1'b0, 4'h0, 11'h005, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    m0_cmd(1'b0, 4'h0, 11'h010, 32'h0);
    sb.push_back('{cyc + 1, M0, 32'hDEADBEEF});
    @(negedge clk);
    total++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      bad++; $display("FAIL rstmid_squash: rvalid=%b%b want 00", m0_rvalid, m1_rvalid);
    end
    total++;
    if (m0_gnt !== 1'b1) begin
      bad++; $display("FAIL rstmid_lock_abandon: m0_gnt=%b want 1", m0_gnt);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL drain: %0d responses outstanding want 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[11'h010] = 32'hDEADBEEF;
    mem[11'h005] = 32'hAABBCCDD;
    mem[11'h020] = 32'h12345678;
    drive_idle();
    test_reset();
    test_read();
    test_write_strobe();
    test_contend();
    test_lock();
    test_nop_write();
    test_reset_mid_read();
    test_drain();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
